axis_align_arb: RTL and testbench
=================================

// Module: axis_align_arb
// PURPOSE
//  Packet-granular round-robin arbiter sharing one axis_align byte packer among
//  N AXI-Stream sources (e.g. TX data-fetch channels). Holds one beat of
//  lookahead so tlast always lands on a beat with non-zero tkeep. The packer has
//  no defined response to tkeep==0, so zero-keep beats never reach it.
// PARAMETERS
//  N   2   number of sources, legal 2..4; data width fixed at 32 bits/4 keep bits
// PORTS
//  aclk        in   1     single clock, all logic on rising edge
//  areset      in   1     synchronous, active-high reset
//  s_tdata     in   N*32  source i at [32*i+31:32*i]
//  s_tkeep     in   N*4   source i at [4*i+3:4*i]
//  s_tlast     in   N     per-source end of packet
//  s_tvalid    in   N     per-source valid
//  s_tready    out  N     per-source ready; only the granted bit can be 1
//  m_tdata     out  32    to aligner s_tdata, driven from hold register H
//  m_tkeep     out  4     to aligner, never 4'b0000 while m_tvalid=1
//  m_tlast     out  1     to aligner
//  m_tvalid    out  1     to aligner
//  m_tready    in   1     from aligner
//  grant       out  N     one-hot current owner, 0 when IDLE
//  empty_pkt   out  1     1-cycle pulse: packet dropped (every beat tkeep==0)
// BEHAVIOUR
//  Reset, synchronous: state=IDLE, grant=0, H empty, rr pointer=0,
//   s_tready=0, m_tvalid=0, m_tlast=0, empty_pkt=0. m_tdata/m_tkeep=0.
//   Reset mid-packet abandons the packet: no further output beats, nothing flushed.
//  FSM IDLE: if any s_tvalid, grant the first requester at or after rr pointer,
//   wrapping modulo N. grant is registered, so BUSY starts the next cycle.
//   s_tready=0 in IDLE.
//  FSM BUSY, source g, H = {data,keep,last,full}. s = granted input beat:
//   a) H.full && H.last: m_tvalid=1, s_tready=0; on m_tready -> H empty,
//      release grant.
//   b) s valid, keep==0, !last: s_tready=1 unconditionally, beat dropped.
//   c) s valid, keep!=0, H empty: s_tready=1, load H; m_tvalid=0.
//   d) s valid, keep!=0, H full, !H.last: m_tvalid=1, m_tlast=0, present H;
//      s_tready=m_tready; on both handshakes H <= s (pass-through replace).
//   e) s valid, keep==0, last, H full: m_tvalid=1, m_tlast forced 1;
//      s_tready=m_tready; on handshake H empty, release grant.
//   f) s valid, keep==0, last, H empty: s_tready=1, consume, pulse empty_pkt,
//      release grant; nothing is sent downstream.
//   g) s not valid: m_tvalid=0 unless case a. A non-last H waits for its successor.
//  Release grant: next state IDLE, rr pointer=g+1 mod N, grant=0. One idle
//   cycle always separates packets.
//  Latency: a non-last beat is output when its successor arrives. A single-beat
//   packet is output the cycle after it is loaded into H.
//  m_* stable while m_tvalid && !m_tready. Never two s_tready bits high.
//  A non-granted source's s_tvalid has no effect until arbitration.
// TESTING
//  1 N=2, both request at reset release, 2-beat pkts keep 1111 -> src0 then src1,
//    grant 01,00,10; output 4 beats, tlast on beats 2 and 4.
//  2 src0 pkt keep {1111,0000 last} -> one output beat keep 1111, m_tlast=1.
//  3 src1 single beat keep 0000 last -> empty_pkt pulse, m_tvalid never 1,
//    rr pointer -> 0.
//  4 m_tready low 5 cycles mid-pkt -> m_* held constant, s_tready low, no loss.
//  5 src0 streams back-to-back pkts, src1 requests -> src1 served after src0's
//    current packet.
//  6 areset pulsed mid-pkt -> next cycle grant=0, m_tvalid=0, s_tready=0.

Source files
------------

// File: rtl/axis_align_arb_if.sv
// AXI-Stream bundle carrying LANES parallel 32-bit streams; LANES=N on the
// source side of the arbiter, LANES=1 toward the aligner.
interface axis_align_arb_if #(
    parameter int LANES = 1
) ();
    logic [LANES*32-1:0] tdata;
    logic [LANES*4-1:0]  tkeep;
    logic [LANES-1:0]    tlast;
    logic [LANES-1:0]    tvalid;
    logic [LANES-1:0]    tready;

    // A beat transfers on a rising edge where tvalid and tready are both 1;
    // the master holds tdata/tkeep/tlast/tvalid until that edge.
    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_align_arb.sv
// Packet-granular round-robin arbiter feeding one byte packer; a one-beat hold
// register keeps tlast on a beat with non-zero tkeep and drops zero-keep beats.
module axis_align_arb #(
    parameter int N = 2
) (
    input  logic                aclk,
    input  logic                areset,
    axis_align_arb_if.slave     s,
    axis_align_arb_if.master    m,
    output logic [N-1:0]        grant,
    output logic                empty_pkt,
    output logic                dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e         state_q;
    logic [N-1:0]   grant_q;
    logic [1:0]     gidx_q;
    logic [1:0]     rr_q;
    logic [31:0]    h_data_q;
    logic [3:0]     h_keep_q;
    logic           h_last_q;
    logic           h_full_q;
    logic           empty_q;

    logic           arb_any;
    logic [1:0]     arb_idx;
    logic [N-1:0]   arb_onehot;
    logic [1:0]     rr_d;

    logic           sel_valid;
    logic [31:0]    sel_data;
    logic [3:0]     sel_keep;
    logic           sel_last;

    logic           m_valid;
    logic           force_last;
    logic           sel_ready;
    logic           load_h;
    logic           clear_h;
    logic           release_g;
    logic           drop_empty;

    // First requester at or after the round-robin pointer, wrapping modulo N.
    always_comb begin
        arb_any = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!arb_any && s.tvalid[(int'(rr_q) + k) % N]) begin
                arb_any = 1'b1;
                arb_idx = 2'((int'(rr_q) + k) % N);
            end
        end
        for (int i = 0; i < N; i++) begin
            arb_onehot[i] = (arb_idx == 2'(i));
        end
    end

    assign rr_d = (gidx_q == 2'(N - 1)) ? 2'd0 : gidx_q + 2'd1;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                sel_valid = s.tvalid[i];
                sel_data  = s.tdata[32*i +: 32];
                sel_keep  = s.tkeep[4*i +: 4];
                sel_last  = s.tlast[i];
            end
        end
    end

    // A buffered non-last beat is only sent once its successor proves whether
    // it is really the final non-empty beat of the packet.
    always_comb begin
        m_valid    = 1'b0;
        force_last = 1'b0;
        sel_ready  = 1'b0;
        load_h     = 1'b0;
        clear_h    = 1'b0;
        release_g  = 1'b0;
        drop_empty = 1'b0;
        if (state_q == BUSY) begin
            if (h_full_q && h_last_q) begin
                m_valid = 1'b1;
                if (m.tready[0]) begin
                    clear_h   = 1'b1;
                    release_g = 1'b1;
                end
            end else if (sel_valid) begin
                if (sel_keep != 4'b0000) begin
                    if (!h_full_q) begin
                        sel_ready = 1'b1;
                        load_h    = 1'b1;
                    end else begin
                        m_valid   = 1'b1;
                        sel_ready = m.tready[0];
                        load_h    = m.tready[0];
                    end
                end else if (!sel_last) begin
                    sel_ready = 1'b1;
                end else if (h_full_q) begin
                    m_valid    = 1'b1;
                    force_last = 1'b1;
                    sel_ready  = m.tready[0];
                    clear_h    = m.tready[0];
                    release_g  = m.tready[0];
                end else begin
                    sel_ready  = 1'b1;
                    drop_empty = 1'b1;
                    release_g  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            h_data_q <= '0;
            h_keep_q <= '0;
            h_last_q <= 1'b0;
            h_full_q <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            empty_q <= drop_empty;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        state_q <= BUSY;
                        grant_q <= arb_onehot;
                        gidx_q  <= arb_idx;
                    end
                end
                BUSY: begin
                    if (load_h) begin
                        h_data_q <= sel_data;
                        h_keep_q <= sel_keep;
                        h_last_q <= sel_last;
                        h_full_q <= 1'b1;
                    end else if (clear_h) begin
                        h_last_q <= 1'b0;
                        h_full_q <= 1'b0;
                    end
                    if (release_g) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        rr_q    <= rr_d;
                    end
                end
            endcase
        end
    end

    assign s.tready    = grant_q & {N{sel_ready}};
    assign m.tvalid[0] = m_valid;
    assign m.tdata     = h_data_q;
    assign m.tkeep     = h_keep_q;
    assign m.tlast[0]  = h_last_q | force_last;
    assign grant       = grant_q;
    assign empty_pkt   = empty_q;
    assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_axis_align_arb.sv
// Directed bench for axis_align_arb (N=2): source queues feed a driver, a
// monitor checks output beats and grant changes against expected queues.
module tb_axis_align_arb;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           areset = 1'b1;
    logic [N-1:0]   grant;
    logic           empty_pkt;
    logic           dbg_state;

    always #5 clk = ~clk;

    axis_align_arb_if #(.LANES(N)) s_if ();
    axis_align_arb_if #(.LANES(1)) m_if ();

    axis_align_arb #(.N(N)) dut (
        .aclk        (clk),
        .areset      (areset),
        .s           (s_if),
        .m           (m_if),
        .grant       (grant),
        .empty_pkt   (empty_pkt),
        .dbg_state_o (dbg_state)
    );

    // Beat encoding: {last, keep[3:0], data[31:0]}
    logic [36:0]    src0_q[$];
    logic [36:0]    src1_q[$];
    logic [36:0]    exp_q[$];
    logic [N-1:0]   exp_grant_q[$];
    int             checks = 0;
    int             failures = 0;
    int             empty_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int src, input logic [31:0] d, input logic [3:0] k, input logic l);
        if (src == 0) src0_q.push_back({l, k, d});
        else          src1_q.push_back({l, k, d});
    endtask

    task automatic expect_out(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({l, k, d});
    endtask

    task automatic expect_grant(input logic [N-1:0] g);
        exp_grant_q.push_back(g);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 &&
                 exp_grant_q.size() == 0 && grant == '0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_%s: timed out with %0d beats and %0d grants still expected",
                     name, exp_q.size(), exp_grant_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Driver: presents the head of each source queue, pops on handshake.
    initial begin
        logic [N-1:0] hs;
        s_if.tvalid = '0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = '0;
        forever begin
            if (src0_q.size() > 0) begin
                {s_if.tlast[0], s_if.tkeep[3:0], s_if.tdata[31:0]} = src0_q[0];
                s_if.tvalid[0] = 1'b1;
            end else begin
                s_if.tvalid[0] = 1'b0;
            end
            if (src1_q.size() > 0) begin
                {s_if.tlast[1], s_if.tkeep[7:4], s_if.tdata[63:32]} = src1_q[0];
                s_if.tvalid[1] = 1'b1;
            end else begin
                s_if.tvalid[1] = 1'b0;
            end
            @(negedge clk);
            hs = s_if.tvalid & s_if.tready;
            @(posedge clk);
            #1;
            if (hs[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (hs[1] && src1_q.size() > 0) void'(src1_q.pop_front());
        end
    end

    // Monitor: output beats, grant sequence and handshake invariants.
    initial begin
        logic [N-1:0] prev_grant;
        logic         prev_stall;
        logic [36:0]  prev_m;
        logic [36:0]  cur_m;
        logic [36:0]  e;
        logic [N-1:0] eg;
        prev_grant = '0;
        prev_stall = 1'b0;
        prev_m     = '0;
        forever begin
            @(negedge clk);
            cur_m = {m_if.tlast[0], m_if.tkeep, m_if.tdata};
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (m_if.tvalid[0] && m_if.tready[0]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_beat: got %0h expected no beat", cur_m);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", 64'(cur_m), 64'(e));
                    end
                end
                if (m_if.tvalid[0]) check("keep_nonzero", 64'(m_if.tkeep != 4'b0000), 64'(1));
                if (prev_stall) check("stall_hold", 64'({m_if.tvalid[0], cur_m}), 64'({1'b1, prev_m}));
                if (m_if.tvalid[0] && !m_if.tready[0]) check("stall_src_ready", 64'(s_if.tready), 64'(0));
                check("ready_onehot", 64'($countones(s_if.tready) <= 1), 64'(1));
                check("ready_in_grant", 64'(s_if.tready & ~grant), 64'(0));
                prev_stall = m_if.tvalid[0] && !m_if.tready[0];
                prev_m     = cur_m;
                if (empty_pkt) empty_seen++;
            end
            if (grant != prev_grant) begin
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_seq: got %0b expected no change", grant);
                end else begin
                    eg = exp_grant_q.pop_front();
                    check("grant_seq", 64'(grant), 64'(eg));
                end
                prev_grant = grant;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_if.tready = 1'b1;
        areset      = 1'b1;

        // 1: both sources request as reset releases, src0 wins, then src1
        push(0, 32'hA000_0001, 4'b1111, 1'b0);
        push(0, 32'hA000_0002, 4'b1111, 1'b1);
        push(1, 32'hB000_0001, 4'b1111, 1'b0);
        push(1, 32'hB000_0002, 4'b1111, 1'b1);
        expect_out(32'hA000_0001, 4'b1111, 1'b0);
        expect_out(32'hA000_0002, 4'b1111, 1'b1);
        expect_out(32'hB000_0001, 4'b1111, 1'b0);
        expect_out(32'hB000_0002, 4'b1111, 1'b1);
        expect_grant(2'b01); expect_grant(2'b00); expect_grant(2'b10); expect_grant(2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant",  64'(grant), 64'(0));
        check("rst_mvalid", 64'(m_if.tvalid), 64'(0));
        check("rst_sready", 64'(s_if.tready), 64'(0));
        check("rst_mlast",  64'(m_if.tlast), 64'(0));
        check("rst_mdata",  64'({m_if.tkeep, m_if.tdata}), 64'(0));
        check("rst_empty",  64'(empty_pkt), 64'(0));
        @(posedge clk);
        #1 areset = 1'b0;
        drain("t1");

        // 2: trailing zero-keep last beat folds tlast onto the held beat
        push(0, 32'hC0C0_C0C0, 4'b1111, 1'b0);
        push(0, 32'hDEAD_BEEF, 4'b0000, 1'b1);
        expect_out(32'hC0C0_C0C0, 4'b1111, 1'b1);
        expect_grant(2'b01); expect_grant(2'b00);
        drain("t2");

        // 3: all-empty packet from src1 is dropped with a pulse
        push(1, 32'h1234_5678, 4'b0000, 1'b1);
        expect_grant(2'b10); expect_grant(2'b00);
        drain("t3");
        check("empty_pulse_t3", 64'(empty_seen), 64'(1));

        // 4: rr pointer back at 0 so src0 wins; downstream stalls mid-packet
        push(0, 32'hE000_0000, 4'b1111, 1'b0);
        push(0, 32'hE000_0001, 4'b0011, 1'b0);
        push(0, 32'hE000_0002, 4'b1000, 1'b1);
        push(1, 32'hF000_0000, 4'b0110, 1'b1);
        expect_out(32'hE000_0000, 4'b1111, 1'b0);
        expect_out(32'hE000_0001, 4'b0011, 1'b0);
        expect_out(32'hE000_0002, 4'b1000, 1'b1);
        expect_out(32'hF000_0000, 4'b0110, 1'b1);
        expect_grant(2'b01); expect_grant(2'b00); expect_grant(2'b10); expect_grant(2'b00);
        repeat (3) @(posedge clk);
        #1 m_if.tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_if.tready = 1'b1;
        drain("t4");

        // 5: src0 back-to-back packets, src1 joins during the first one
        push(0, 32'h6000_0000, 4'b1111, 1'b0);
        push(0, 32'h6000_00FF, 4'b0000, 1'b0);
        push(0, 32'h6000_0001, 4'b1100, 1'b1);
        push(0, 32'h7000_0000, 4'b1111, 1'b1);
        expect_out(32'h6000_0000, 4'b1111, 1'b0);
        expect_out(32'h6000_0001, 4'b1100, 1'b1);
        expect_out(32'h8000_0000, 4'b0001, 1'b1);
        expect_out(32'h7000_0000, 4'b1111, 1'b1);
        expect_grant(2'b01); expect_grant(2'b00); expect_grant(2'b10);
        expect_grant(2'b00); expect_grant(2'b01); expect_grant(2'b00);
        repeat (2) @(posedge clk);
        #1 push(1, 32'h8000_0000, 4'b0001, 1'b1);
        drain("t5");

        // 6: reset mid-packet abandons it
        m_if.tready = 1'b0;
        push(0, 32'h9000_0000, 4'b1111, 1'b0);
        push(0, 32'h9000_0001, 4'b1111, 1'b0);
        push(0, 32'h9000_0002, 4'b1111, 1'b1);
        expect_grant(2'b01); expect_grant(2'b00);
        repeat (4) @(posedge clk);
        #1 areset = 1'b1;
        src0_q.delete();
        @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        check("t6_grant",  64'(grant), 64'(0));
        check("t6_mvalid", 64'(m_if.tvalid), 64'(0));
        check("t6_sready", 64'(s_if.tready), 64'(0));
        m_if.tready = 1'b1;
        drain("t6");

        check("empty_total", 64'(empty_seen), 64'(1));
        check("exp_beats_left", 64'(exp_q.size()), 64'(0));
        check("exp_grants_left", 64'(exp_grant_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
